program_result_monitor: RTL

- Synthesizable run monitor for CPU program tests; generalizes single-register end-of-run checks.
- Snoops the CPU data-memory write port for stores to a mailbox window of NUM_CHECKS words.
- Detects program halt (rom_addr stuck, e.g. "jal x0,0") or timeout, then compares captured words against parametrised expected values.
- Reports pass/fail/timeout with diagnostics. Sits beside cpu/ram in benches and FPGA top-levels.

---
 rtl/program_result_monitor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/program_result_monitor.sv
// program_result_monitor
//
// Watches a CPU for the end of a self-checking program run. Stores that hit
// a mailbox window of NUM_CHECKS words are captured. When the fetch address
// stops moving (halt) or the run budget expires (timeout), the captured words
// are judged against EXPECTED and the verdict is held until reset.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   mem_wr_sig   CPU data-memory write strobe
//   mem_addr     CPU data-memory byte address
//   mem_wr_data  CPU store data
//   rom_addr     CPU instruction fetch address
//   done         run finished (sticky)
//   pass         all slots matched (meaningful with done)
//   timeout      run ended by timeout
//   fail_index   lowest failing slot; all ones on timeout; 0 on pass
//   fail_data    captured value of the failing slot; 0 if never written/timeout
//   cycle_count  cycles spent in RUN; frozen once done
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_RUN     | program executing; capturing mailbox stores, watching halt
// S_PASS    | halted with every slot written and matching
// S_FAIL    | halted with a bad/missing slot, or early mismatching store
// S_TIMEOUT | run budget exhausted without a halt

module program_result_monitor #(
    parameter int                         NUM_CHECKS     = 4,
    parameter logic [31:0]                MAILBOX_BASE   = 32'h0000_0100,
    parameter logic [32*NUM_CHECKS-1:0]   EXPECTED       = '0,
    parameter int                         TIMEOUT_CYCLES = 500,
    parameter int                         HALT_CYCLES    = 8,
    parameter int                         EARLY_FAIL     = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mem_wr_sig,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_wr_data,
    input  logic [31:0]                   rom_addr,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [$clog2(NUM_CHECKS):0]   fail_index,
    output logic [31:0]                   fail_data,
    output logic [31:0]                   cycle_count
);

    localparam int          IW          = $clog2(NUM_CHECKS) + 1;
    localparam int          SW          = $clog2(HALT_CYCLES + 1);
    localparam logic [SW-1:0] HALT_TC   = SW'(HALT_CYCLES);
    localparam logic [31:0] TIMEOUT_TC  = 32'(TIMEOUT_CYCLES - 1);
    // 33 bits so a window ending at the top of the address space cannot wrap
    localparam logic [32:0] MAILBOX_END = {1'b0, MAILBOX_BASE} + 33'(4 * NUM_CHECKS);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t                  state, state_nxt;
    logic [31:0]             slot_val [NUM_CHECKS];
    logic [NUM_CHECKS-1:0]   slot_vld;
    logic [31:0]             prev_rom;
    logic [SW-1:0]           stable_cnt;

    logic [31:0]             mb_off;
    logic [IW-1:0]           mb_slot;
    logic                    mb_hit;
    logic [31:0]             mb_exp;
    logic                    early_fail;
    logic                    halt;
    logic                    budget_out;

    // Slot view after this cycle's capture, so a store landing on the halt
    // cycle still takes part in the evaluation.
    logic [31:0]             view_val [NUM_CHECKS];
    logic [NUM_CHECKS-1:0]   view_vld;
    logic                    any_fail;
    logic [IW-1:0]           eval_idx;
    logic [31:0]             eval_data;

    logic                    done_nxt, pass_nxt, timeout_nxt;
    logic [IW-1:0]           fail_index_nxt;
    logic [31:0]             fail_data_nxt;

    // ---------------------------------------------------------------- decode
    always_comb begin
        mb_off  = mem_addr - MAILBOX_BASE;
        mb_slot = IW'(mb_off >> 2);
        mb_hit  = (state == S_RUN) && mem_wr_sig && (mem_addr[1:0] == 2'b00) &&
                  (mem_addr >= MAILBOX_BASE) && ({1'b0, mem_addr} < MAILBOX_END);
        mb_exp  = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (mb_slot == IW'(i)) mb_exp = EXPECTED[32*i +: 32];
        end
        early_fail = (EARLY_FAIL != 0) && mb_hit && (mem_wr_data != mb_exp);
        halt       = (state == S_RUN) && (stable_cnt == HALT_TC);
        budget_out = (state == S_RUN) && (cycle_count == TIMEOUT_TC);
    end

    // ------------------------------------------------------------ evaluation
    always_comb begin
        any_fail  = 1'b0;
        eval_idx  = '0;
        eval_data = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (mb_hit && (mb_slot == IW'(i))) begin
                view_vld[i] = 1'b1;
                view_val[i] = mem_wr_data;
            end else begin
                view_vld[i] = slot_vld[i];
                view_val[i] = slot_val[i];
            end
        end
        // Scan downward so the lowest failing slot is the one that sticks.
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (!view_vld[i] || (view_val[i] != EXPECTED[32*i +: 32])) begin
                any_fail  = 1'b1;
                eval_idx  = IW'(i);
                eval_data = view_vld[i] ? view_val[i] : 32'd0;
            end
        end
    end

    // --------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RUN;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_index <= '0;
            fail_data  <= '0;
        end else begin
            state      <= state_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            timeout    <= timeout_nxt;
            fail_index <= fail_index_nxt;
            fail_data  <= fail_data_nxt;
        end
    end

    // ------------------------------------------------------ FSM: next state
    always_comb begin
        state_nxt = state;
        if (state == S_RUN) begin
            if (early_fail)      state_nxt = S_FAIL;
            else if (halt)       state_nxt = any_fail ? S_FAIL : S_PASS;
            else if (budget_out) state_nxt = S_TIMEOUT;
        end
    end

    // ---------------------------------------------------------- FSM: outputs
    always_comb begin
        done_nxt       = done;
        pass_nxt       = pass;
        timeout_nxt    = timeout;
        fail_index_nxt = fail_index;
        fail_data_nxt  = fail_data;
        if (state == S_RUN) begin
            case (state_nxt)
                S_PASS: begin
                    done_nxt       = 1'b1;
                    pass_nxt       = 1'b1;
                    fail_index_nxt = '0;
                    fail_data_nxt  = '0;
                end
                S_FAIL: begin
                    done_nxt       = 1'b1;
                    pass_nxt       = 1'b0;
                    fail_index_nxt = early_fail ? mb_slot : eval_idx;
                    fail_data_nxt  = early_fail ? mem_wr_data : eval_data;
                end
                S_TIMEOUT: begin
                    done_nxt       = 1'b1;
                    pass_nxt       = 1'b0;
                    timeout_nxt    = 1'b1;
                    fail_index_nxt = '1;
                    fail_data_nxt  = '0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_rom    <= '0;
            stable_cnt  <= '0;
            cycle_count <= '0;
            slot_vld    <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) slot_val[i] <= '0;
        end else begin
            prev_rom <= rom_addr;
            if (rom_addr == prev_rom) begin
                if (stable_cnt != HALT_TC) stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
            end
            if ((state == S_RUN) && (cycle_count != 32'hFFFF_FFFF))
                cycle_count <= cycle_count + 32'd1;
            slot_vld <= view_vld;
            for (int i = 0; i < NUM_CHECKS; i++) slot_val[i] <= view_val[i];
        end
    end

endmodule
